// File: rtl/fifo_uart_tx_pkg.sv
// ============================================================================
// Module : fifo_uart_tx_pkg
// Brief  : Shared FSM encodings and parity-type constants for fifo_uart_tx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage : fifo_uart_tx_pkg

`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// Module : fifo_uart_tx_if
// Brief  : FIFO read-port bundle (empty / head word / pop strobe).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  r_inc;

    // master = consumer that pops, slave = FIFO that presents the head word
    modport master (
        input  empty,
        input  rd_data,
        output r_inc
    );

    modport slave (
        output empty,
        output rd_data,
        input  r_inc
    );
endinterface : fifo_uart_tx_if

`default_nettype wire

// File: rtl/fifo_uart_tx_parity.sv
// ============================================================================
// Module : uart_parity_calc
// Brief  : Combinational even/odd parity bit over a DATA_WIDTH payload.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_parity_calc
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic [DATA_WIDTH-1:0] data,
    input  wire logic                  par_typ,
    output logic                       par_bit
);

    always_comb begin
        par_bit = (^data) ^ (par_typ == PAR_ODD);
    end

endmodule : uart_parity_calc

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module : fifo_uart_tx
// Brief  : Drains an async-FIFO read port and serialises each word as a UART
//          frame (start, LSB-first data, optional parity, stop), 1 bit/clk.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fifo_uart_tx_if.master      rd_if,
    input  wire logic           par_en,
    input  wire logic           par_typ,
    output logic                tx_out,
    output logic                busy
);

    localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             r_state,   w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
    logic                  r_par_en,  w_par_en_nxt;
    logic                  r_par_typ, w_par_typ_nxt;
    logic                  r_tx,      w_tx_nxt;
    logic                  r_busy,    w_busy_nxt;
    logic                  r_rinc,    w_rinc_nxt;
    logic                  w_capture;
    logic                  w_par_bit;

    // Rotation (not a plain shift) keeps the payload intact; XOR parity is rotation-invariant
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (r_shift),
        .par_typ (r_par_typ),
        .par_bit (w_par_bit)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_rinc_nxt    = 1'b0;
        w_capture     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt  = 1'b1;
                w_capture = !rd_if.empty;
            end
            ST_START: begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
            end
            ST_DATA: begin
                if (r_cnt == LAST_BIT) begin
                    w_cnt_nxt = '0;
                    if (r_par_en) begin
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = w_par_bit;
                    end else begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
                end
            end
            ST_PARITY: begin
                w_state_nxt = ST_STOP;
                w_tx_nxt    = 1'b1;
            end
            ST_STOP: begin
                if (!rd_if.empty) begin
                    w_capture = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_capture) begin
            w_state_nxt   = ST_START;
            w_shift_nxt   = rd_if.rd_data;
            w_par_en_nxt  = par_en;
            w_par_typ_nxt = par_typ;
            w_tx_nxt      = 1'b0;
            w_rinc_nxt    = 1'b1;
            w_busy_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_rinc    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_typ <= w_par_typ_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_rinc    <= w_rinc_nxt;
        end
    end

    assign tx_out      = r_tx;
    assign busy        = r_busy;
    assign rd_if.r_inc = r_rinc;

endmodule : fifo_uart_tx

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module : tb_fifo_uart_tx
// Brief  : Directed scoreboard bench for fifo_uart_tx with a small FIFO model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int DW = 8;

    typedef struct {
        logic [10:0] bits;   // first line cycle is the leftmost digit of a len-digit literal
        int          len;
    } frame_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic par_en  = 1'b0;
    logic par_typ = PAR_EVEN;
    logic tx_out;
    logic busy;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_if   (bus),
        .par_en  (par_en),
        .par_typ (par_typ),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cycle  = 0;

    assign bus.empty   = (wr_ptr == rd_ptr);
    assign bus.rd_data = mem[rd_ptr % 16];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.r_inc) rd_ptr <= rd_ptr + 1;
    end

    frame_t exp_q[$];
    int     rinc_cyc[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_active = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: a pop starts a frame; compare every line bit against the queued frame
    initial begin
        frame_t cur;
        int     idx;
        cur.bits = '0;
        cur.len  = 0;
        idx      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                continue;
            end
            if (bus.r_inc) begin
                rinc_cyc.push_back(cycle);
                if (mon_active) chk("frame_cut_short", idx, cur.len);
                if (bus.empty === 1'b1 && rd_ptr > wr_ptr) chk("pop_past_empty", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                    mon_active = 1'b0;
                end else begin
                    cur        = exp_q.pop_front();
                    idx        = 0;
                    mon_active = 1'b1;
                end
            end
            if (mon_active) begin
                chk($sformatf("tx_bit%0d", idx), tx_out, cur.bits[cur.len-1-idx]);
                chk($sformatf("busy_bit%0d", idx), busy, 1);
                if (idx > 0) chk($sformatf("rinc_bit%0d", idx), bus.r_inc, 0);
                idx++;
                if (idx == cur.len) mon_active = 1'b0;
            end
        end
    end

    task automatic push(input logic [DW-1:0] b, input logic [10:0] bits, input int len);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        exp_q.push_back(f);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((exp_q.size() != 0 || mon_active) && n < budget);
        if (exp_q.size() != 0 || mon_active) chk("idle_timeout", 1, 0);
        @(negedge clk);
        #1;
        chk("busy_after_frame", busy, 0);
        chk("tx_idle_after_frame", tx_out, 1);
    endtask

    task automatic wait_pop(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (bus.r_inc !== 1'b1 && n < budget);
        if (bus.r_inc !== 1'b1) chk("pop_timeout", 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with data available: idle outputs, no pop
        rst_n = 1'b0;
        @(negedge clk);
        push(8'hA5, 11'b0101001011, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("rst_tx", tx_out, 1);
            chk("rst_busy", busy, 0);
            chk("rst_rinc", bus.r_inc, 0);
        end
        chk("rst_no_pop", rd_ptr, 0);

        // 0xA5 without parity
        rst_n = 1'b1;
        wait_idle(40);
        chk("a5_pop_count", rinc_cyc.size(), 1);

        // 0x03 with even then odd parity
        par_en  = 1'b1;
        par_typ = PAR_EVEN;
        push(8'h03, 11'b01100000001, 11);
        wait_idle(40);
        par_typ = PAR_ODD;
        push(8'h03, 11'b01100000011, 11);
        wait_idle(40);

        // Back-to-back frames
        par_en = 1'b0;
        rinc_cyc.delete();
        push(8'h55, 11'b0101010101, 10);
        push(8'h0F, 11'b0111100001, 10);
        wait_idle(60);
        chk("b2b_pop_count", rinc_cyc.size(), 2);
        if (rinc_cyc.size() == 2) chk("b2b_pop_spacing", rinc_cyc[1] - rinc_cyc[0], 10);

        // Reset during data bit 3 of 0x00, then 0xA5 must follow cleanly
        push(8'h00, 11'b0000000001, 10);
        push(8'hA5, 11'b0101001011, 10);
        wait_pop(20);
        repeat (4) @(negedge clk);
        #1;
        chk("pre_abort_tx", tx_out, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", tx_out, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rinc", bus.r_inc, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        wait_idle(40);
        chk("fifo_drained", rd_ptr, wr_ptr);

        // Long empty stretch
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            chk("empty_rinc", bus.r_inc, 0);
            chk("empty_tx", tx_out, 1);
            chk("empty_busy", busy, 0);
        end

        // Parity settings changed mid-frame are ignored
        par_en  = 1'b0;
        par_typ = PAR_EVEN;
        push(8'h55, 11'b0101010101, 10);
        wait_pop(20);
        par_en  = 1'b1;
        par_typ = PAR_EVEN;
        wait_idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_uart_tx

`default_nettype wire
